// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART frame parser.
package uart_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } parser_state_e;

  // Index width that stays legal when the buffer holds a single byte.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: simple dual-port RAM, synchronous write, registered read (1-cycle latency).
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Frame parser (SOF, LEN, payload, CHK) behind the UART receiver; buffers good payloads and streams them out.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | hunting for SOF, other bytes ignored
// ST_LEN     | waiting for LEN byte, range checked
// ST_PAYLOAD | writing payload bytes into buffer, XOR running
// ST_CHK     | comparing CHK byte against running XOR
// ST_DRAIN   | streaming buffered payload with valid/ready
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = 2170
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Data_DV,
  output logic [7:0] o_Data_Byte,
  output logic       o_Data_Last,
  input  logic       i_Data_Ready,
  output logic       o_Err_Len,
  output logic       o_Err_Chk,
  output logic       o_Err_Timeout,
  output logic       o_Overrun
);

  localparam int IDX_W = idx_width(MAX_LEN);

  parser_state_e    state_q;
  logic [7:0]       len_q;
  logic [7:0]       chk_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic             data_dv_q;
  logic             data_last_q;
  logic             err_len_q;
  logic             err_chk_q;
  logic             overrun_q;

  logic             hs;
  logic             wr_en;
  logic             to_fire;
  logic [IDX_W-1:0] rd_addr;
  logic [7:0]       rd_data;

  assign hs    = data_dv_q & i_Data_Ready;
  assign wr_en = (state_q == ST_PAYLOAD) && i_RX_DV;

  // Prefetch: address 0 is read while waiting for CHK, and the next index is
  // read on each handshake, so the RAM output always matches the presented byte.
  always_comb begin
    rd_addr = '0;
    if (state_q == ST_DRAIN) begin
      if (hs && !data_last_q) begin
        rd_addr = rd_idx_q + 1'b1;
      end else begin
        rd_addr = rd_idx_q;
      end
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IDX_W)
  ) u_buf (
    .clk_i     (i_Clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_idx_q),
    .wr_data_i (i_RX_Byte),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      chk_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      data_dv_q   <= 1'b0;
      data_last_q <= 1'b0;
      err_len_q   <= 1'b0;
      err_chk_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      overrun_q <= 1'b0;
      if (to_fire) begin
        state_q  <= ST_IDLE;
        wr_idx_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (i_RX_DV && (i_RX_Byte == SOF_BYTE)) begin
              state_q <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (i_RX_DV) begin
              len_q    <= i_RX_Byte;
              chk_q    <= i_RX_Byte;
              wr_idx_q <= '0;
              if ((i_RX_Byte == 8'd0) || (i_RX_Byte > 8'(MAX_LEN))) begin
                err_len_q <= 1'b1;
                state_q   <= ST_IDLE;
              end else begin
                state_q <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (i_RX_DV) begin
              chk_q    <= chk_q ^ i_RX_Byte;
              wr_idx_q <= wr_idx_q + 1'b1;
              if ((8'(wr_idx_q) + 8'd1) == len_q) begin
                state_q <= ST_CHK;
              end
            end
          end
          ST_CHK: begin
            if (i_RX_DV) begin
              if (i_RX_Byte == chk_q) begin
                state_q     <= ST_DRAIN;
                data_dv_q   <= 1'b1;
                data_last_q <= (len_q == 8'd1);
                rd_idx_q    <= '0;
              end else begin
                err_chk_q <= 1'b1;
                state_q   <= ST_IDLE;
              end
            end
          end
          ST_DRAIN: begin
            if (i_RX_DV) begin
              overrun_q <= 1'b1;
            end
            if (hs) begin
              if (data_last_q) begin
                data_dv_q   <= 1'b0;
                data_last_q <= 1'b0;
                rd_idx_q    <= '0;
                wr_idx_q    <= '0;
                state_q     <= ST_IDLE;
              end else begin
                rd_idx_q    <= rd_idx_q + 1'b1;
                data_last_q <= ((8'(rd_idx_q) + 8'd2) == len_q);
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            err_to_q;
  logic            in_frame;

  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  // Fires on the idle cycle that brings the count to TIMEOUT_CLKS.
  assign to_fire  = in_frame && !i_RX_DV && (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      err_to_q <= to_fire;
      if (!in_frame || i_RX_DV || to_fire) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  assign o_Err_Timeout = err_to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CLKS[0];
  assign to_fire            = 1'b0;
  assign o_Err_Timeout      = 1'b0;
`endif

  assign o_Data_DV   = data_dv_q;
  assign o_Data_Byte = data_dv_q ? rd_data : 8'h00;
  assign o_Data_Last = data_last_q;
  assign o_Err_Len   = err_len_q;
  assign o_Err_Chk   = err_chk_q;
  assign o_Overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Self-checking bench for uart_rx_frame_parser: table-driven frames plus corner-case sequences.
module tb_uart_rx_frame_parser;

  localparam int MAX_LEN      = 16;
  localparam int TIMEOUT_CLKS = 2170;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       ready = 1'b1;
  logic       o_Data_DV, o_Data_Last, o_Err_Len, o_Err_Chk, o_Err_Timeout, o_Overrun;
  logic [7:0] o_Data_Byte;

  always #5 clk = ~clk;

  uart_rx_frame_parser #(
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .i_Clock       (clk),
    .i_Rst_L       (rst_l),
    .i_RX_DV       (rx_dv),
    .i_RX_Byte     (rx_byte),
    .o_Data_DV     (o_Data_DV),
    .o_Data_Byte   (o_Data_Byte),
    .o_Data_Last   (o_Data_Last),
    .i_Data_Ready  (ready),
    .o_Err_Len     (o_Err_Len),
    .o_Err_Chk     (o_Err_Chk),
    .o_Err_Timeout (o_Err_Timeout),
    .o_Overrun     (o_Overrun)
  );

  typedef struct {
    int start;
    int n;
    int pay_off;
    int exp_len;
    int exp_chk;
    int exp_out;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] pool[$];
  logic [8:0] sb[$];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_len = 0, n_chk = 0, n_to = 0, n_ovr = 0, n_hs = 0;
  int first_hs = 0, last_hs = 0;
  int b_len, b_chk, b_to, b_ovr, k;
  logic       prev_ok = 1'b0, prev_dv = 1'b0, prev_rdy = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    step();
    rx_dv   = 1'b1;
    rx_byte = b;
    step();
    rx_dv   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while ((sb.size() != 0 || o_Data_DV) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain: got %0d bytes still pending, expected 0", tag, sb.size());
    end
    repeat (2) step();
  endtask

  task automatic add_vec(input logic [127:0] pk, input int n, input int pay_off,
                         input int el, input int ec, input int eo);
    vec_t v;
    v.start   = pool.size();
    v.n       = n;
    v.pay_off = pay_off;
    v.exp_len = el;
    v.exp_chk = ec;
    v.exp_out = eo;
    for (int i = 0; i < n; i++) pool.push_back(pk[8*(n-1-i) +: 8]);
    vecs.push_back(v);
  endtask

  task automatic push_exp(input logic [7:0] b, input logic last);
    sb.push_back({last, b});
  endtask

  // Output monitor: scoreboard pop on handshake, hold-stable check, pulse counters.
  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (o_Err_Len) n_len++;
    if (o_Err_Chk) n_chk++;
    if (o_Err_Timeout) n_to++;
    if (o_Overrun) n_ovr++;
    if (rst_l && prev_ok && prev_dv && !prev_rdy) begin
      check("hold_stable", 32'({o_Data_DV, o_Data_Last, o_Data_Byte}),
            32'({1'b1, prev_last, prev_byte}));
    end
    if (rst_l && o_Data_DV && ready) begin
      n_hs++;
      if (n_hs == 1) first_hs = cyc;
      last_hs = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got %02h, expected no output", o_Data_Byte);
      end else begin
        e = sb.pop_front();
        check("payload", 32'({o_Data_Last, o_Data_Byte}), 32'(e));
      end
    end
    prev_ok   = rst_l;
    prev_dv   = o_Data_DV;
    prev_rdy  = ready;
    prev_last = o_Data_Last;
    prev_byte = o_Data_Byte;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] pk;
    logic [7:0]   x, b;
    vec_t         v;

    add_vec(128'h42, 1, 0, 0, 0, 0);
    add_vec(128'hA500, 2, 0, 1, 0, 0);
    pk = 128'(16'hA500 | 16'(MAX_LEN + 1));
    add_vec(pk, 2, 0, 1, 0, 0);
    add_vec(128'hA5FF, 2, 0, 1, 0, 0);
    add_vec(128'hA5_03_11_22_33_03, 6, 2, 0, 0, 3);
    add_vec(128'hA5_02_AA_BB_00, 5, 0, 0, 1, 0);
    add_vec(128'hA5_02_AA_BB_13, 5, 2, 0, 0, 2);
    add_vec(128'hA5_01_A5_A4, 4, 2, 0, 0, 1);
    add_vec(128'h00_A5_01_5A_5B, 5, 3, 0, 0, 1);
    // Full-length frame; checksum computed by the bench.
    v.start = pool.size(); v.n = MAX_LEN + 3; v.pay_off = 2;
    v.exp_len = 0; v.exp_chk = 0; v.exp_out = MAX_LEN;
    pool.push_back(8'hA5);
    pool.push_back(8'(MAX_LEN));
    x = 8'(MAX_LEN);
    for (int j = 0; j < MAX_LEN; j++) begin
      b = 8'(j * 13 + 7);
      pool.push_back(b);
      x = x ^ b;
    end
    pool.push_back(x);
    vecs.push_back(v);

    repeat (3) step();
    @(negedge clk);
    check("reset_outputs", 32'({o_Data_DV, o_Data_Last, o_Data_Byte, o_Err_Len, o_Err_Chk,
                                o_Err_Timeout, o_Overrun}), 0);
    step();
    rst_l = 1'b1;
    repeat (2) step();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      b_len = n_len; b_chk = n_chk; b_ovr = n_ovr; b_to = n_to; n_hs = 0;
      for (int j = 0; j < v.exp_out; j++) push_exp(pool[v.start + v.pay_off + j], j == v.exp_out - 1);
      for (int j = 0; j < v.n; j++) send_byte(pool[v.start + j]);
      if (v.exp_out > 0) begin
        @(negedge clk);
        check("first_dv_latency", 32'(o_Data_DV), 1);
      end
      wait_idle("vec");
      check("err_len_count", n_len - b_len, v.exp_len);
      check("err_chk_count", n_chk - b_chk, v.exp_chk);
      check("out_count", n_hs, v.exp_out);
      check("overrun_count", n_ovr - b_ovr, 0);
      check("timeout_count", n_to - b_to, 0);
      if (v.exp_out > 1) check("throughput", last_hs - first_hs, v.exp_out - 1);
    end

    // Backpressure: first byte held while ready is low.
    n_hs = 0;
    ready = 1'b0;
    push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b0); push_exp(8'h33, 1'b1);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h03);
    @(negedge clk);
    check("bp_first_dv", 32'({o_Data_DV, o_Data_Byte}), 32'h111);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("bp_hold_byte", 32'(o_Data_Byte), 32'h11);
    end
    step();
    ready = 1'b1;
    wait_idle("bp");
    check("bp_out_count", n_hs, 3);

    // Overrun during drain leaves payload untouched.
    n_hs = 0; b_ovr = n_ovr;
    ready = 1'b0;
    push_exp(8'h10, 1'b0); push_exp(8'h20, 1'b1);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h32);
    send_byte(8'h55);
    @(negedge clk);
    check("overrun_pulse", 32'(o_Overrun), 1);
    check("overrun_byte_kept", 32'({o_Data_DV, o_Data_Byte}), 32'h110);
    step();
    ready = 1'b1;
    wait_idle("ovr");
    check("overrun_once", n_ovr - b_ovr, 1);
    check("overrun_out_count", n_hs, 2);

    // Byte strobed in the same cycle as the final handshake is also an overrun.
    n_hs = 0; b_ovr = n_ovr;
    push_exp(8'hA5, 1'b1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA5); send_byte(8'hA4);
    rx_dv = 1'b1; rx_byte = 8'h55;
    step();
    rx_dv = 1'b0;
    @(negedge clk);
    check("overrun_last_hs", 32'({o_Overrun, o_Data_DV}), 32'h2);
    wait_idle("ovr_last");
    check("overrun_last_count", n_ovr - b_ovr, 1);
    check("overrun_last_out", n_hs, 1);

    // Reset mid-frame, then a good frame.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    step(); rst_l = 1'b0; step(); rst_l = 1'b1;
    @(negedge clk);
    check("rst_frame_outputs", 32'({o_Data_DV, o_Data_Last, o_Data_Byte, o_Err_Len, o_Err_Chk,
                                    o_Err_Timeout, o_Overrun}), 0);
    n_hs = 0; b_len = n_len; b_chk = n_chk;
    push_exp(8'hAA, 1'b0); push_exp(8'hBB, 1'b1);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h13);
    wait_idle("rst_frame");
    check("rst_frame_out", n_hs, 2);
    check("rst_frame_errs", (n_len - b_len) + (n_chk - b_chk), 0);

    // Reset mid-drain abandons the buffer; next frame starts at index 0.
    ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h03);
    step(); rst_l = 1'b0; step(); rst_l = 1'b1;
    @(negedge clk);
    check("rst_drain_outputs", 32'({o_Data_DV, o_Data_Last, o_Data_Byte, o_Err_Len, o_Err_Chk,
                                    o_Err_Timeout, o_Overrun}), 0);
    step();
    ready = 1'b1;
    n_hs = 0;
    push_exp(8'h77, 1'b1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h77); send_byte(8'h76);
    wait_idle("rst_drain");
    check("rst_drain_out", n_hs, 1);

`ifdef UART_FRAME_TIMEOUT_EN
    b_to = n_to;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    k = 0;
    @(negedge clk);
    while (!o_Err_Timeout && k < TIMEOUT_CLKS + 20) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, TIMEOUT_CLKS);
    repeat (3) step();
    check("timeout_once", n_to - b_to, 1);
    b_to = n_to;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    repeat (20) step();
    rst_l = 1'b0; step(); rst_l = 1'b1;
    @(negedge clk);
    check("timeout_rst_outputs", 32'({o_Data_DV, o_Data_Last, o_Data_Byte, o_Err_Len, o_Err_Chk,
                                      o_Err_Timeout, o_Overrun}), 0);
    repeat (TIMEOUT_CLKS + 10) step();
    check("timeout_after_rst", n_to - b_to, 0);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_parser.md
# uart_rx_frame_parser

Frame parser that sits directly downstream of the UART receiver and consumes its one-cycle byte-valid strobes. It finds framed packets of the form SOF, LEN, payload, CHK in the byte stream and validates the length and checksum. Good payloads are buffered and then streamed out with a valid/ready handshake. Bad frames are discarded and reported with error pulses.

## Interface
- MAX_LEN, 16, maximum payload bytes per frame (1..255)
- TIMEOUT_CLKS, 2170, idle clocks allowed between bytes inside a frame (10 bit times at 217 clocks per bit)
- i_Clock  in  1  system clock; all logic on rising edge
- i_Rst_L  in  1  reset; synchronous and active-low
- i_RX_DV  in  1  one-cycle strobe from the UART receiver: i_RX_Byte is valid
- i_RX_Byte  in  8  received byte
- o_Data_DV  out  1  payload byte valid
- o_Data_Byte  out  8  payload byte
- o_Data_Last  out  1  marks the final payload byte of the frame; qualified by o_Data_DV
- i_Data_Ready  in  1  downstream accepts the byte when o_Data_DV and i_Data_Ready are both 1
- o_Err_Len  out  1  one-cycle pulse: LEN is 0 or greater than MAX_LEN
- o_Err_Chk  out  1  one-cycle pulse: checksum mismatch
- o_Err_Timeout  out  1  one-cycle pulse: inter-byte timeout fired
- o_Overrun  out  1  one-cycle pulse: a byte arrived while in DRAIN and was dropped

## Operation
- Frame format: SOF = 0xA5, then LEN, then LEN payload bytes, then CHK.
- CHK = XOR of LEN and all payload bytes.
- States and transitions:
  - IDLE: an i_RX_DV with byte 0xA5 moves to LEN. Any other byte is ignored silently, with no error.
  - LEN: capture LEN and seed the running XOR with it. If LEN is 0 or greater than MAX_LEN, pulse o_Err_Len and go to IDLE. Otherwise go to PAYLOAD.
  - PAYLOAD: write each byte into the buffer at the write index and XOR it into the running checksum. After byte LEN, go to CHK.
  - CHK: if the byte equals the running XOR, go to DRAIN. Otherwise pulse o_Err_Chk and go to IDLE.
  - DRAIN: present buffered bytes 0..LEN-1 in order. After the handshake on the last byte, go to IDLE.
- A 0xA5 byte inside LEN, PAYLOAD or CHK is treated as data. There is no resynchronisation mid-frame.
- Any i_RX_DV while in DRAIN drops the byte and pulses o_Overrun. This includes the cycle of the final handshake.
- Reset mid-frame or mid-drain: the next cycle is IDLE, the indices are cleared, and the buffered payload is abandoned.

## Timing
- All outputs reset to 0. The state, indices, checksum and timeout counter are also cleared.
- Error pulses are registered: asserted for exactly the one cycle after the offending byte's i_RX_DV cycle.
- First payload byte: if the CHK byte is strobed in cycle N, o_Data_DV rises in cycle N+1.
- While o_Data_DV is 1 and i_Data_Ready is 0, o_Data_Byte and o_Data_Last hold stable.
- After each handshake, the next byte is presented in the following cycle. A throughput of 1 byte per clock is required.
- o_Data_DV deasserts in the cycle after the last handshake.
- Buffer read latency (1 cycle) is hidden by prefetch. o_Data_Byte must be valid in the same cycle o_Data_DV rises.
- Widths:
  - write and read index: $clog2(MAX_LEN)
  - length register: 8 bits
  - timeout counter: $clog2(TIMEOUT_CLKS+1)

## Configuration
- UART_FRAME_TIMEOUT_EN defined:
  - In LEN, PAYLOAD and CHK, the counter increments on each cycle without i_RX_DV and clears on i_RX_DV.
  - When the count reaches TIMEOUT_CLKS, pulse o_Err_Timeout and go to IDLE.
  - The counter is held at 0 in IDLE and DRAIN.
- Not defined:
  - No counter is built.
  - A partial frame waits indefinitely.
  - o_Err_Timeout is tied to 0.

## Structure
- Shared package uart_pkg holds:
  - the SOF constant 0xA5
  - the parser state enum (IDLE, LEN, PAYLOAD, CHK, DRAIN)
- One sub-module, uart_frame_buf:
  - simple dual-port RAM of MAX_LEN x 8
  - one synchronous write port, one synchronous read port with 1-cycle latency
- The FSM, checksum, timeout and output handshake live in the top module.

## Test plan
- Good frame, downstream always ready:
  - Stimulus: strobes A5 03 11 22 33 03 (CHK = 03^11^22^33 = 03).
  - Required: o_Data_DV for 3 consecutive cycles carrying 11, 22, 33, with o_Data_Last on 33. No error pulses.
- Backpressure:
  - Stimulus: same frame, with i_Data_Ready held low for 5 cycles after o_Data_DV rises.
  - Required: 11 held stable throughout. Order and count unchanged.
- Bad checksum:
  - Stimulus: A5 02 AA BB 00 (expected 13).
  - Required: one o_Err_Chk pulse, no o_Data_DV. A following good frame is then parsed correctly.
- Bad length:
  - Stimulus: A5 00, then A5 with LEN = MAX_LEN+1.
  - Required: two o_Err_Len pulses. A byte 0x42 before any SOF produces no pulse.
- Overrun:
  - Stimulus: good frame with i_Data_Ready low, then strobe byte 0x55 during DRAIN.
  - Required: o_Overrun pulses once, and the payload output is unchanged.
- Timeout (UART_FRAME_TIMEOUT_EN defined):
  - Stimulus: A5 04 01, then silence.
  - Required: o_Err_Timeout pulses TIMEOUT_CLKS cycles after the 01 strobe. A reset asserted mid-frame in a second run returns all outputs to 0.
